// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC selection and IF/ID register.
// One bubble per taken redirect; no delay slot.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  jump,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instr_id,
  output logic [31:0] pc4_id,
  output logic [5:0]  op_code,
  output logic [5:0]  funct_code,
  output logic        valid_id,
  output logic        misaligned,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic        mis_q, mis_d;

  logic [31:0] pc_plus4;
  logic [31:0] jr_tgt;
  logic [31:0] j_tgt;
  logic        take_jr;
  logic        take_j;
  logic        take_br;
  logic        redirect;

  assign pc_plus4 = pc_q + 32'd4;
  assign jr_tgt   = {jr_target[31:2], 2'b00};
  assign j_tgt    = {pc4_q[31:28], jump_index, 2'b00};

  // A bubble in IF/ID cannot redirect; jump=11 behaves like no jump.
  assign take_jr  = valid_q && (jump == 2'b10);
  assign take_j   = valid_q && (jump == 2'b01);
  assign take_br  = valid_q && branch_taken;
  assign redirect = take_jr || take_j || take_br;

  // Next state: stall holds, redirect flushes, otherwise fetch sequentially.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    mis_d   = 1'b0;
    if (!stall) begin
      pc4_d = pc_plus4;
      if (redirect) begin
        instr_d = NOP_WORD;
        valid_d = 1'b0;
        if (take_jr) begin
          pc_d  = jr_tgt;
          mis_d = |jr_target[1:0];
        end else if (take_j) begin
          pc_d = j_tgt;
        end else begin
          pc_d = branch_target;
        end
      end else begin
        pc_d    = pc_plus4;
        instr_d = imem_data;
        valid_d = 1'b1;
        cnt_d   = cnt_q + 32'd1;
      end
    end
  end

  // State registers; reset clears everything without waiting for clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instr_id    = instr_q;
  assign pc4_id      = pc4_q;
  assign op_code     = instr_q[31:26];
  assign funct_code  = instr_q[5:0];
  assign valid_id    = valid_q;
  assign misaligned  = mis_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: stimulus pushes expected IF state,
// a monitor pops and compares after each edge or on demand.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [1:0]  jump = 2'b00;
  logic [25:0] jump_index = 26'd0;
  logic [31:0] jr_target = 32'd0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instr_id;
  logic [31:0] pc4_id;
  logic [5:0]  op_code;
  logic [5:0]  funct_code;
  logic        valid_id;
  logic        misaligned;
  logic [31:0] fetch_count;

  int n_assert = 0;
  int n_fail = 0;

  typedef struct {
    string       nm;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] cnt;
    logic        valid;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  event chk_ev;

  function automatic logic [31:0] w(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign imem_data = w(imem_addr);

  if_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .jump         (jump),
    .jump_index   (jump_index),
    .jr_target    (jr_target),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .instr_id     (instr_id),
    .pc4_id       (pc4_id),
    .op_code      (op_code),
    .funct_code   (funct_code),
    .valid_id     (valid_id),
    .misaligned   (misaligned),
    .fetch_count  (fetch_count)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input string f,
                     input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", nm, f, act, exp);
    end
  endtask

  // Monitor: pops one expectation per trigger and compares all outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp(e.nm, "imem_addr", imem_addr, e.addr);
        cmp(e.nm, "instr_id", instr_id, e.instr);
        cmp(e.nm, "pc4_id", pc4_id, e.pc4);
        cmp(e.nm, "fetch_count", fetch_count, e.cnt);
        cmp(e.nm, "valid_id", {31'd0, valid_id}, {31'd0, e.valid});
        cmp(e.nm, "misaligned", {31'd0, misaligned}, {31'd0, e.mis});
        cmp(e.nm, "op_code", {26'd0, op_code}, {26'd0, e.instr[31:26]});
        cmp(e.nm, "funct_code", {26'd0, funct_code}, {26'd0, e.instr[5:0]});
      end
    end
  end

  function automatic exp_t mk(input string nm, input logic [31:0] a,
                              input logic [31:0] i, input logic [31:0] p,
                              input logic [31:0] c, input logic v,
                              input logic m);
    exp_t e;
    e.nm = nm; e.addr = a; e.instr = i; e.pc4 = p;
    e.cnt = c; e.valid = v; e.mis = m;
    return e;
  endfunction

  task automatic step(input exp_t e);
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic now(input exp_t e);
    sb.push_back(e);
    -> chk_ev;
    #2;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    now(mk("rst", 32'h0040_0000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0));
    reset = 1'b0;
    step(mk("s1", 32'h0040_0004, w(32'h0040_0000), 32'h0040_0004, 1, 1, 0));
    step(mk("s2", 32'h0040_0008, w(32'h0040_0004), 32'h0040_0008, 2, 1, 0));
    step(mk("s3", 32'h0040_000C, w(32'h0040_0008), 32'h0040_000C, 3, 1, 0));
    step(mk("s4", 32'h0040_0010, w(32'h0040_000C), 32'h0040_0010, 4, 1, 0));

    stall = 1'b1; jump = 2'b01; jump_index = 26'h3FF;
    branch_taken = 1'b1; branch_target = 32'h0000_0800;
    for (int k = 0; k < 3; k++)
      step(mk("stall", 32'h0040_0010, w(32'h0040_000C), 32'h0040_0010,
              4, 1, 0));
    stall = 1'b0; jump = 2'b00; branch_taken = 1'b0;
    step(mk("s5", 32'h0040_0014, w(32'h0040_0010), 32'h0040_0014, 5, 1, 0));
    step(mk("s6", 32'h0040_0018, w(32'h0040_0014), 32'h0040_0018, 6, 1, 0));
    step(mk("s7", 32'h0040_001C, w(32'h0040_0018), 32'h0040_001C, 7, 1, 0));
    step(mk("s8", 32'h0040_0020, w(32'h0040_001C), 32'h0040_0020, 8, 1, 0));

    reset = 1'b1; jump = 2'b10; jr_target = 32'h0000_0123;
    now(mk("arst", 32'h0040_0000, 32'd0, 32'd0, 0, 0, 0));
    step(mk("arst_hold", 32'h0040_0000, 32'd0, 32'd0, 0, 0, 0));
    jump = 2'b00; reset = 1'b0;
    step(mk("rel1", 32'h0040_0004, w(32'h0040_0000), 32'h0040_0004, 1, 1, 0));
    step(mk("rel2", 32'h0040_0008, w(32'h0040_0004), 32'h0040_0008, 2, 1, 0));

    jump = 2'b01; jump_index = 26'h000_0010;
    step(mk("jmp", 32'h0000_0040, 32'd0, 32'h0040_000C, 2, 0, 0));
    jump = 2'b00;
    branch_taken = 1'b1; branch_target = 32'h0000_1000;
    step(mk("jmp_tgt", 32'h0000_0044, w(32'h0000_0040), 32'h0000_0044,
            3, 1, 0));
    branch_taken = 1'b0;

    stall = 1'b1; jump = 2'b10; jr_target = 32'h0040_0103;
    branch_taken = 1'b1; branch_target = 32'h0000_3000;
    step(mk("prio_stall", 32'h0000_0044, w(32'h0000_0040), 32'h0000_0044,
            3, 1, 0));
    stall = 1'b0;
    step(mk("prio_jr", 32'h0040_0100, 32'd0, 32'h0000_0048, 3, 0, 1));
    jump = 2'b00; branch_taken = 1'b0;
    step(mk("jr_tgt", 32'h0040_0104, w(32'h0040_0100), 32'h0040_0104,
            4, 1, 0));

    branch_taken = 1'b1; branch_target = 32'h0000_2000;
    step(mk("br", 32'h0000_2000, 32'd0, 32'h0040_0108, 4, 0, 0));
    branch_taken = 1'b0;
    step(mk("br_tgt", 32'h0000_2004, w(32'h0000_2000), 32'h0000_2004,
            5, 1, 0));

    jump = 2'b10; jr_target = 32'hFFFF_FFFC;
    step(mk("jr_hi", 32'hFFFF_FFFC, 32'd0, 32'h0000_2008, 5, 0, 0));
    jump = 2'b00;
    step(mk("wrap", 32'h0000_0000, w(32'hFFFF_FFFC), 32'h0000_0000,
            6, 1, 0));
    jump = 2'b11; jump_index = 26'h0AB_CDEF;
    step(mk("j11", 32'h0000_0004, w(32'h0000_0000), 32'h0000_0004,
            7, 1, 0));
    jump = 2'b00;

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations pending, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, default 32'h0040_0000, PC value loaded on reset.
REQ-002 Parameter: NOP_WORD, default 32'h0000_0000, instruction word placed in IF/ID on flush or reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 stall  input  1  hold PC and IF/ID contents.
REQ-006 jump  input  2  from decode: 00 none, 01 J/JAL, 10 JR, 11 treated as 00.
REQ-007 jump_index  input  26  instr[25:0] of the decode-stage instruction.
REQ-008 jr_target  input  32  rs value for JR.
REQ-009 branch_taken  input  1  decode-stage branch resolved taken.
REQ-010 branch_target  input  32  branch destination.
REQ-011 imem_addr  output  32  fetch address, equals current PC, combinational from the PC register.
REQ-012 imem_data  input  32  instruction word returned combinationally for imem_addr.
REQ-013 instr_id  output  32  IF/ID instruction register.
REQ-014 pc4_id  output  32  IF/ID register holding fetch PC + 4.
REQ-015 op_code  output  6  instr_id[31:26].
REQ-016 funct_code  output  6  instr_id[5:0].
REQ-017 valid_id  output  1  IF/ID holds a real instruction.
REQ-018 misaligned  output  1  one-cycle pulse when a JR target has nonzero bits [1:0].
REQ-019 fetch_count  output  32  number of instructions written valid into IF/ID.

Function
REQ-020 The next-PC priority shall be stall, then JR (jump=10), then J/JAL (jump=01), then branch_taken, then PC+4.
REQ-021 While stall=1, PC, instr_id, pc4_id, valid_id and fetch_count shall hold, and jump and branch inputs shall be ignored.
REQ-022 The J/JAL target shall be {pc4_id[31:28], jump_index, 2'b00}.
REQ-023 The JR target shall be {jr_target[31:2], 2'b00}.
REQ-024 misaligned shall be registered high for exactly the cycle after an accepted JR with jr_target[1:0]!=0, and low otherwise.
REQ-025 Redirects shall be accepted only when valid_id=1; redirect inputs arriving with valid_id=0 shall be ignored.
REQ-026 On an accepted redirect, the next edge shall load PC with the target and flush IF/ID: instr_id=NOP_WORD, valid_id=0, pc4_id=old PC+4.
REQ-027 The fetched instruction in the redirect cycle shall be discarded, giving 1 bubble per taken jump or branch, with no delay slot.
REQ-028 On a no-stall, no-redirect edge: PC<=PC+4, instr_id<=imem_data, pc4_id<=PC+4, valid_id<=1, fetch_count<=fetch_count+1.
REQ-029 PC+4 shall wrap modulo 2^32 (32'hFFFF_FFFC -> 0) with no flag.
REQ-030 fetch_count shall wrap modulo 2^32.
REQ-031 A flushed cycle shall not increment fetch_count.
REQ-032 Fetch latency: the word at address A shall appear on instr_id one edge after imem_addr=A is accepted.

Reset
REQ-033 On assertion of reset, without waiting for clk: PC=RESET_PC, instr_id=NOP_WORD, pc4_id=0, valid_id=0, misaligned=0, fetch_count=0.
REQ-034 On the first rising edge after reset deasserts, the block shall fetch RESET_PC and set valid_id=1 on that edge.
REQ-035 Reset asserted mid-stall or mid-redirect shall override both; no pending redirect shall survive reset.

Verification
REQ-036 Straight line: reset, then 4 edges with imem returning A0..A3 -> instr_id sequence A0..A3, pc4_id 0x00400004..0x00400010, fetch_count=4.
REQ-037 Stall: stall=1 for 3 edges mid-stream -> PC, instr_id and fetch_count unchanged; resume with the next sequential word.
REQ-038 Jump: valid_id=1, pc4_id=0x00400008, jump=01, jump_index=0x0000010 -> next imem_addr=0x00000040, valid_id=0 for 1 cycle, then target word appears.
REQ-039 Priority: jump=10 with jr_target=0x00400103 and branch_taken=1 in the same cycle -> PC=0x00400100 and misaligned pulses 1 cycle; with stall=1 also asserted, the PC is unchanged.
REQ-040 Async reset: reset asserted between clock edges while PC=0x00400020 -> outputs at reset values immediately; first edge after release fetches 0x00400000.
REQ-041 Wrap: force PC to 0xFFFFFFFC, one edge -> imem_addr=0, pc4_id=0.
